pwm_ramp_ctrl: RTL and testbench

Duty-cycle sequencer that sits in front of the PWM generator and drives its duty input.
- Accepts a target duty over a valid/ready handshake.
- Ramps the live duty toward the target in programmable steps.
- Applies a duty change only on PWM period boundaries, so the output never glitches mid-period.
- Gives soft-start / fade control without software polling.

---
 rtl/pwm_ramp_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_ctrl.sv
// Duty-cycle ramp sequencer feeding a PWM generator; duty changes on period boundaries.
// Optional sticky completion flag: define PWM_RAMP_CTRL_STICKY_DONE_EN.
module pwm_ramp_ctrl #(
    parameter int BITS_DUTY = 4,
    parameter int DIV_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 period_end,
    input  logic [BITS_DUTY-1:0] target_duty,
    input  logic [BITS_DUTY-1:0] step_size,
    input  logic [DIV_W-1:0]     step_div,
    input  logic                 target_valid,
    output logic                 target_ready,
    input  logic                 abort,
`ifdef PWM_RAMP_CTRL_STICKY_DONE_EN
    input  logic                 done_clr,
    output logic                 done_flag,
`endif
    output logic [BITS_DUTY-1:0] duty_out,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RAMP,
        S_DONE
    } state_e;

    localparam logic [BITS_DUTY-1:0] ONE = {{(BITS_DUTY-1){1'b0}}, 1'b1};

    state_e               state_q, state_d;
    logic [BITS_DUTY-1:0] duty_q, duty_d;
    logic [BITS_DUTY-1:0] tgt_q, tgt_d;
    logic [BITS_DUTY-1:0] step_q, step_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [DIV_W-1:0]     cnt_q, cnt_d;
    logic                 done_q, done_d;

    logic [BITS_DUTY:0]   duty_x, tgt_x, step_x;
    logic [BITS_DUTY:0]   up_sum, dn_dif;
    logic [BITS_DUTY-1:0] stepped;

    assign duty_x = {1'b0, duty_q};
    assign tgt_x  = {1'b0, tgt_q};
    assign step_x = {1'b0, step_q};
    assign up_sum = duty_x + step_x;
    assign dn_dif = duty_x - step_x;

    // Extra bit catches carry/borrow so the step clamps to target instead of wrapping.
    always_comb begin
        stepped = tgt_q;
        if (tgt_q > duty_q) begin
            if (up_sum < tgt_x) begin
                stepped = up_sum[BITS_DUTY-1:0];
            end
        end else begin
            if (!dn_dif[BITS_DUTY] && (dn_dif > tgt_x)) begin
                stepped = dn_dif[BITS_DUTY-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        tgt_d   = tgt_q;
        step_d  = step_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (target_valid) begin
                    tgt_d   = target_duty;
                    step_d  = (step_size == '0) ? ONE : step_size;
                    div_d   = step_div;
                    cnt_d   = step_div;
                    state_d = (target_duty == duty_q) ? S_DONE : S_RAMP;
                end
            end
            S_RAMP: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (enable && period_end) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        duty_d = stepped;
                        cnt_d  = div_q;
                        if (stepped == tgt_q) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            duty_q  <= '0;
            tgt_q   <= '0;
            step_q  <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            tgt_q   <= tgt_d;
            step_q  <= step_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

`ifdef PWM_RAMP_CTRL_STICKY_DONE_EN
    logic flag_q, flag_d;
    logic abort_hit;

    assign abort_hit = (state_q == S_RAMP) && abort;

    // Set follows the visible done pulse, so a clear in that same cycle loses.
    always_comb begin
        flag_d = flag_q;
        if (done_q) begin
            flag_d = 1'b1;
        end else if (done_clr || abort_hit) begin
            flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flag_q <= 1'b0;
        end else begin
            flag_q <= flag_d;
        end
    end

    assign done_flag = flag_q;
`endif

    assign target_ready = (state_q == S_IDLE);
    assign busy         = (state_q == S_RAMP);
    assign done         = done_q;
    assign duty_out     = duty_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Randomized bench for pwm_ramp_ctrl against a step-sequence reference model.
// Model precomputes the duty sequence and indexes it by counted period pulses.
module tb_pwm_ramp_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       period_end;
    logic [3:0] target_duty;
    logic [3:0] step_size;
    logic [7:0] step_div;
    logic       target_valid;
    logic       target_ready;
    logic       abort;
    logic [3:0] duty_out;
    logic       busy;
    logic       done;
`ifdef PWM_RAMP_CTRL_STICKY_DONE_EN
    logic       done_clr;
    logic       done_flag;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int cur    = 0;
    bit en_rand = 0;

    pwm_ramp_ctrl #(.BITS_DUTY(4), .DIV_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .period_end   (period_end),
        .target_duty  (target_duty),
        .step_size    (step_size),
        .step_div     (step_div),
        .target_valid (target_valid),
        .target_ready (target_ready),
        .abort        (abort),
`ifdef PWM_RAMP_CTRL_STICKY_DONE_EN
        .done_clr     (done_clr),
        .done_flag    (done_flag),
`endif
        .duty_out     (duty_out),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_chk++;
        if (obs == exp_v) n_pass++;
        else $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, obs, exp_v, cyc);
    endtask

    task automatic tick();
        period_end = (cyc % 8 == 7);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic ramp(input int tgt, input int stp, input int div,
                        input int abort_d, input int rst_d, input int pause_d);
        int seq[$];
        int d;
        int s;
        int n;
        int idx;
        int exp_d;
        int hold;
        int budget;
        bit pe;
        bit en;
        s = (stp == 0) ? 1 : stp;
        d = cur;
        while (d != tgt) begin
            if (tgt > d) d = (d + s > tgt) ? tgt : d + s;
            else         d = (d - s < tgt) ? tgt : d - s;
            seq.push_back(d);
        end
        chk("idle_ready", int'(target_ready), 1);
        target_duty  = 4'(tgt);
        step_size    = 4'(stp);
        step_div     = 8'(div);
        target_valid = 1'b1;
        enable       = 1'b1;
        abort        = en_rand ? 1'($urandom_range(0, 1)) : 1'b0;
        tick();
        target_valid = 1'b0;
        abort        = 1'b0;
        if (seq.size() == 0) begin
            chk("same_done", int'(done), 1);
            chk("same_busy", int'(busy), 0);
            chk("same_rdy", int'(target_ready), 0);
            chk("same_duty", int'(duty_out), cur);
            tick();
            chk("same_done_end", int'(done), 0);
            chk("same_rdy_end", int'(target_ready), 1);
            chk("same_busy_end", int'(busy), 0);
            return;
        end
        chk("acc_busy", int'(busy), 1);
        chk("acc_rdy", int'(target_ready), 0);
        chk("acc_duty", int'(duty_out), cur);
        n = 0;
        hold = 0;
        budget = 0;
        forever begin
            idx   = n / (div + 1);
            exp_d = (idx == 0) ? cur : seq[idx-1];
            pe    = (cyc % 8 == 7);
            en    = en_rand ? ($urandom_range(0, 9) != 0) : 1'b1;
            if (pause_d == exp_d && hold == 0) begin
                hold    = 24;
                pause_d = -1;
            end
            if (hold > 0) begin
                en = 1'b0;
                hold--;
            end
            enable = en;
            if (en_rand) begin
                target_valid = 1'($urandom_range(0, 1));
                target_duty  = 4'($urandom_range(0, 15));
            end
            if (abort_d == exp_d && pe) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                target_valid = 1'b0;
                chk("abort_duty", int'(duty_out), exp_d);
                chk("abort_busy", int'(busy), 0);
                chk("abort_rdy", int'(target_ready), 1);
                chk("abort_done", int'(done), 0);
                cur = exp_d;
                return;
            end
            if (rst_d == exp_d) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                target_valid = 1'b0;
                chk("rst_duty", int'(duty_out), 0);
                chk("rst_busy", int'(busy), 0);
                chk("rst_rdy", int'(target_ready), 1);
                chk("rst_done", int'(done), 0);
                cur = 0;
                return;
            end
            tick();
            if (en && pe) n++;
            idx = n / (div + 1);
            if (idx >= seq.size()) begin
                target_valid = 1'b0;
                chk("fin_duty", int'(duty_out), tgt);
                chk("fin_done", int'(done), 1);
                chk("fin_busy", int'(busy), 0);
                chk("fin_rdy", int'(target_ready), 0);
                // A request held during the DONE cycle must not be taken.
                target_valid = 1'b1;
                target_duty  = 4'(15 - tgt);
                tick();
                target_valid = 1'b0;
                chk("post_done", int'(done), 0);
                chk("post_rdy", int'(target_ready), 1);
                chk("post_busy", int'(busy), 0);
                chk("post_duty", int'(duty_out), tgt);
                cur = tgt;
                return;
            end
            exp_d = (idx == 0) ? cur : seq[idx-1];
            chk("ramp_duty", int'(duty_out), exp_d);
            chk("ramp_done", int'(done), 0);
            chk("ramp_busy", int'(busy), 1);
            budget++;
            if (budget > 4000) begin
                chk("timeout", budget, 4000);
                return;
            end
        end
    endtask

    initial begin
        int t;
        int s;
        int dv;
        int ab;
        rst          = 1'b1;
        enable       = 1'b1;
        period_end   = 1'b0;
        target_duty  = '0;
        step_size    = '0;
        step_div     = '0;
        target_valid = 1'b0;
        abort        = 1'b0;
`ifdef PWM_RAMP_CTRL_STICKY_DONE_EN
        done_clr     = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;
        chk("rst_duty0", int'(duty_out), 0);
        chk("rst_busy0", int'(busy), 0);
        chk("rst_rdy0", int'(target_ready), 1);
        chk("rst_done0", int'(done), 0);
        tick();

        ramp(12, 4, 0, -1, -1, -1);
        ramp(1, 5, 1, -1, -1, -1);
        ramp(5, 4, 0, -1, -1, -1);
        ramp(5, 3, 0, -1, -1, -1);
        ramp(0, 15, 0, -1, -1, -1);
        ramp(15, 1, 0, 6, -1, 3);
        ramp(15, 1, 0, -1, 9, -1);
        ramp(3, 1, 0, -1, -1, -1);
        ramp(7, 0, 0, -1, -1, -1);
        ramp(15, 15, 2, -1, -1, -1);

        en_rand = 1;
        for (int i = 0; i < 30; i++) begin
            t  = $urandom_range(0, 15);
            s  = $urandom_range(0, 15);
            dv = $urandom_range(0, 2);
            ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15)) : -1;
            ramp(t, s, dv, ab, -1, -1);
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
